det_nxn: RTL and testbench

DET_NXN -- requirements
Module: det_nxn

---
 rtl/det_pkg.sv | 67 ++++++
 rtl/det_mac.sv | 71 +++++++
 rtl/det_nxn.sv | 139 +++++++++++++
 tb/tb_det_nxn.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// Shared types for the det_nxn determinant engine: FSM states, mode and
// element-count constants, and the per-cycle multiply-accumulate schedule.
package det_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  localparam logic MODE_3X3 = 1'b0;
  localparam logic MODE_2X2 = 1'b1;

  localparam int unsigned N_ELEM_3X3 = 9;
  localparam int unsigned N_ELEM_2X2 = 4;
  localparam int unsigned N_STEP_3X3 = 9;
  localparam int unsigned N_STEP_2X2 = 2;

  // One multiplier issue: x operand is always an element, y is an element or
  // the running 2x2 minor; the product lands in the minor or the accumulator.
  typedef struct packed {
    logic [3:0] sel_x;
    logic [3:0] sel_y;
    logic       y_minor;
    logic       dst_minor;
    logic       sub;
    logic       clr;
  } mac_ctrl_t;

  function automatic mac_ctrl_t mk_ctrl(input logic [3:0] x, input logic [3:0] y,
                                        input logic ym, input logic dm,
                                        input logic sub, input logic clr);
    mac_ctrl_t c;
    c.sel_x     = x;
    c.sel_y     = y;
    c.y_minor   = ym;
    c.dst_minor = dm;
    c.sub       = sub;
    c.clr       = clr;
    return c;
  endfunction

  // Elements are row-major: a b c / d e f / g h i -> indices 0..8.
  // 3x3 expands by the first row: a(ei-fh) - b(di-fg) + c(dh-eg).
  function automatic mac_ctrl_t mac_schedule(input logic mode, input logic [3:0] step);
    mac_ctrl_t c;
    c = '0;
    if (mode == MODE_2X2) begin
      case (step)
        4'd0:    c = mk_ctrl(4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        4'd1:    c = mk_ctrl(4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        default: c = '0;
      endcase
    end else begin
      case (step)
        4'd0:    c = mk_ctrl(4'd4, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1);
        4'd1:    c = mk_ctrl(4'd5, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
        4'd2:    c = mk_ctrl(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        4'd3:    c = mk_ctrl(4'd3, 4'd8, 1'b0, 1'b1, 1'b0, 1'b1);
        4'd4:    c = mk_ctrl(4'd5, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0);
        4'd5:    c = mk_ctrl(4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        4'd6:    c = mk_ctrl(4'd3, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1);
        4'd7:    c = mk_ctrl(4'd4, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0);
        4'd8:    c = mk_ctrl(4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        default: c = '0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/det_mac.sv
// Shared signed multiplier with a 2x2-minor register and an ACC_W add/subtract
// accumulator; operand routing comes from the det_pkg schedule each cycle.
module det_mac
  import det_pkg::*;
#(
  parameter int W     = 32,
  parameter int ACC_W = 3*W+2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  mac_ctrl_t               ctrl_i,
  input  logic signed [W-1:0]     elem_i [9],
  output logic signed [ACC_W-1:0] acc_next_o
);

  localparam int MW = 2*W+1;
  localparam int PW = 3*W+1;

  logic signed [W-1:0]     x;
  logic signed [W-1:0]     y_elem;
  logic signed [MW-1:0]    y;
  logic        [PW-1:0]    x_ext;
  logic        [PW-1:0]    y_ext;
  logic        [PW-1:0]    prod;
  logic signed [MW-1:0]    minor_q, minor_d, minor_base;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_base, acc_term;

  always_comb begin
    x      = '0;
    y_elem = '0;
    for (int k = 0; k < 9; k++) begin
      if (ctrl_i.sel_x == k[3:0]) x = elem_i[k];
      if (ctrl_i.sel_y == k[3:0]) y_elem = elem_i[k];
    end
  end

  // The y operand is widened to hold a minor so a*(ei-fh) stays exact.
  assign y     = ctrl_i.y_minor ? minor_q : {{(W+1){y_elem[W-1]}}, y_elem};
  assign x_ext = {{(PW-W){x[W-1]}}, x};
  assign y_ext = {{(PW-MW){y[MW-1]}}, y};
  assign prod  = x_ext * y_ext;

  assign acc_term = {{(ACC_W-PW){prod[PW-1]}}, prod};

  always_comb begin
    minor_base = ctrl_i.clr ? '0 : minor_q;
    acc_base   = ctrl_i.clr ? '0 : acc_q;
    minor_d    = minor_q;
    acc_d      = acc_q;
    if (en_i && ctrl_i.dst_minor) begin
      minor_d = ctrl_i.sub ? minor_base - prod[MW-1:0] : minor_base + prod[MW-1:0];
    end
    if (en_i && !ctrl_i.dst_minor) begin
      acc_d = ctrl_i.sub ? acc_base - acc_term : acc_base + acc_term;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      minor_q <= '0;
      acc_q   <= '0;
    end else begin
      minor_q <= minor_d;
      acc_q   <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/det_nxn.sv
// Streaming 3x3 / 2x2 signed determinant engine (IDLE -> LOAD -> CALC -> DONE).
// Define DET_NXN_SAT_EN to saturate det on overflow instead of wrapping.
module det_nxn
  import det_pkg::*;
#(
  parameter int W     = 32,
  parameter int ACC_W = 3*W+2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_data,
  output logic                in_ready,
  output logic signed [W-1:0] det,
  output logic                ovf,
  output logic                busy,
  output logic                done
);

  state_t              state_q;
  logic                mode_q;
  logic [3:0]          cnt_q;
  logic [3:0]          step_q;
  logic                in_ready_q, busy_q, done_q, ovf_q;
  logic signed [W-1:0] det_q, det_d;
  logic                ovf_d;
  logic signed [W-1:0] elem_q [9];

  logic                    accept;
  logic [3:0]              last_elem, last_step;
  mac_ctrl_t               mac_ctrl;
  logic signed [ACC_W-1:0] acc_next;
  logic [ACC_W-W:0]        acc_hi;

  assign accept    = (state_q == LOAD) && in_valid && in_ready_q;
  assign last_elem = (mode_q == MODE_2X2) ? 4'(N_ELEM_2X2 - 1) : 4'(N_ELEM_3X3 - 1);
  assign last_step = (mode_q == MODE_2X2) ? 4'(N_STEP_2X2 - 1) : 4'(N_STEP_3X3 - 1);
  assign mac_ctrl  = mac_schedule(mode_q, step_q);

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_elem
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          elem_q[gi] <= '0;
        end else if (accept && (cnt_q == 4'(gi))) begin
          elem_q[gi] <= in_data;
        end
      end
    end
  endgenerate

  det_mac #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst        (reset),
    .en_i       (state_q == CALC),
    .ctrl_i     (mac_ctrl),
    .elem_i     (elem_q),
    .acc_next_o (acc_next)
  );

  // Representable in W bits iff every bit from W-1 upward matches the sign.
  assign acc_hi = acc_next[ACC_W-1:W-1];
  assign ovf_d  = !((&acc_hi) || !(|acc_hi));

`ifdef DET_NXN_SAT_EN
  assign det_d = !ovf_d            ? acc_next[W-1:0] :
                 acc_next[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} :
                                     {1'b0, {(W-1){1'b1}}};
`else
  assign det_d = acc_next[W-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE_3X3;
      cnt_q      <= '0;
      step_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      det_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q     <= mode;
            cnt_q      <= '0;
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (cnt_q == last_elem) begin
              state_q    <= CALC;
              in_ready_q <= 1'b0;
              step_q     <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        CALC: begin
          // The final product is folded in combinationally and captured here.
          if (step_q == last_step) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            det_q   <= det_d;
            ovf_q   <= ovf_d;
          end else begin
            step_q <= step_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign det      = det_q;
  assign ovf      = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_det_nxn.sv
// Directed bench for det_nxn: one W=32 and one W=8 instance share the same
// input stream; expected values are hand-computed constants.
module tb_det_nxn;

`ifdef DET_NXN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;

  logic        rdy32, ovf32, busy32, done32;
  logic [31:0] det32;
  logic        rdy8, ovf8, busy8, done8;
  logic [7:0]  det8;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  det_nxn #(.W(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy32),
    .det(det32), .ovf(ovf32), .busy(busy32), .done(done32)
  );

  det_nxn #(.W(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .in_valid(in_valid), .in_data(in_data[7:0]), .in_ready(rdy8),
    .det(det8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Runs one operation; lat is cycles from last accept to done (0 = timeout).
  task automatic run_op(input logic m, input int n, input int gap, input int ev[9],
                        input bit pulse, output int lat, output bit rdy_calc,
                        output int extra_done, output bit d8_sync);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = ev[i];
      for (int t = 0; t < 20 && !rdy32; t++) @(negedge clk);
      @(negedge clk);
      if (gap > 0 && i < n-1) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = 32'h7F7F_7F7F;
    lat = 0;
    rdy_calc = 1'b0;
    d8_sync = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      start = pulse && (k == 3);
      if (done32) begin
        lat = k;
        d8_sync = done8;
        break;
      end
      rdy_calc |= rdy32;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = pulse;
    @(negedge clk);
    start = 1'b0;
    extra_done = 0;
    repeat (15) begin
      if (done32) extra_done++;
      @(negedge clk);
    end
  endtask

  initial begin
    int vec[9];
    int lat, extra;
    bit rc, d8s;

    repeat (3) @(negedge clk);
    check("rst_det32", det32, 32'd0);
    check("rst_ovf32", {31'd0, ovf32}, 32'd0);
    check("rst_busy32", {31'd0, busy32}, 32'd0);
    check("rst_rdy32", {31'd0, rdy32}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    vec = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
    run_op(1'b0, 9, 0, vec, 1'b0, lat, rc, extra, d8s);
    $display("[TB] diag3 det32=%0d ovf32=%0b det8=%0d lat=%0d", $signed(det32), ovf32, $signed(det8), lat);
    check("diag_det32", det32, 32'd24);
    check("diag_ovf32", {31'd0, ovf32}, 32'd0);
    check("diag_lat", lat, 32'd10);
    check("diag_det8", {24'd0, det8}, 32'd24);
    check("diag_done8_sync", {31'd0, d8s}, 32'd1);
    check("diag_busy_after", {31'd0, busy32}, 32'd0);

    vec = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    run_op(1'b1, 4, 2, vec, 1'b0, lat, rc, extra, d8s);
    $display("[TB] 2x2 gaps det32=%0d lat=%0d", $signed(det32), lat);
    check("gap_det32", det32, 32'hFFFF_FFFE);
    check("gap_lat", lat, 32'd3);
    check("gap_rdy_in_calc", {31'd0, rc}, 32'd0);
    check("gap_rdy_idle", {31'd0, rdy32}, 32'd0);
    check("gap_det8", {24'd0, det8}, 32'h0000_00FE);

    vec = '{100, 0, 0, 100, 0, 0, 0, 0, 0};
    run_op(1'b1, 4, 0, vec, 1'b0, lat, rc, extra, d8s);
    $display("[TB] 2x2 pos-ovf det8=%0d ovf8=%0b det32=%0d", $signed(det8), ovf8, $signed(det32));
    check("povf_ovf8", {31'd0, ovf8}, 32'd1);
    check("povf_det8", {24'd0, det8}, SAT ? 32'd127 : 32'd16);
    check("povf_det32", det32, 32'd10000);
    check("povf_ovf32", {31'd0, ovf32}, 32'd0);

    vec = '{0, 100, 100, 0, 0, 0, 0, 0, 0};
    run_op(1'b1, 4, 0, vec, 1'b0, lat, rc, extra, d8s);
    $display("[TB] 2x2 neg-ovf det8=%0d ovf8=%0b det32=%0d", $signed(det8), ovf8, $signed(det32));
    check("novf_ovf8", {31'd0, ovf8}, 32'd1);
    check("novf_det8", {24'd0, det8}, SAT ? 32'h80 : 32'hF0);
    check("novf_det32", det32, 32'hFFFF_D8F0);

    vec = '{2, -3, 1, 4, 5, -6, 7, -8, 9};
    run_op(1'b0, 9, 1, vec, 1'b1, lat, rc, extra, d8s);
    $display("[TB] 3x3 mixed+start pulses det32=%0d det8=%0d lat=%0d extra=%0d", $signed(det32), $signed(det8), lat, extra);
    check("mix_det32", det32, 32'd161);
    check("mix_lat", lat, 32'd10);
    check("mix_extra_done", extra, 32'd0);
    check("mix_busy_after", {31'd0, busy32}, 32'd0);
    check("mix_ovf8", {31'd0, ovf8}, 32'd1);
    check("mix_det8", {24'd0, det8}, SAT ? 32'h7F : 32'hA1);

    vec = '{100000, 0, 0, 0, 100000, 0, 0, 0, 1};
    run_op(1'b0, 9, 0, vec, 1'b0, lat, rc, extra, d8s);
    $display("[TB] 3x3 big det32=0x%0h ovf32=%0b det8=%0d", det32, ovf32, $signed(det8));
    check("big_ovf32", {31'd0, ovf32}, 32'd1);
    check("big_det32", det32, SAT ? 32'h7FFF_FFFF : 32'h540B_E400);
    check("big_ovf8", {31'd0, ovf8}, 32'd1);
    check("big_det8", {24'd0, det8}, SAT ? 32'h7F : 32'h00);

    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("midload_busy", {31'd0, busy32}, 32'd1);
    reset = 1'b1;
    #1;
    $display("[TB] reset mid-load det32=%0d busy32=%0b rdy32=%0b", $signed(det32), busy32, rdy32);
    check("arst_det32", det32, 32'd0);
    check("arst_ovf32", {31'd0, ovf32}, 32'd0);
    check("arst_busy32", {31'd0, busy32}, 32'd0);
    check("arst_rdy32", {31'd0, rdy32}, 32'd0);
    check("arst_done32", {31'd0, done32}, 32'd0);
    check("arst_ovf8", {31'd0, ovf8}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    vec = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    run_op(1'b0, 9, 0, vec, 1'b0, lat, rc, extra, d8s);
    $display("[TB] identity det32=%0d det8=%0d lat=%0d", $signed(det32), $signed(det8), lat);
    check("ident_det32", det32, 32'd1);
    check("ident_det8", {24'd0, det8}, 32'd1);
    check("ident_lat", lat, 32'd10);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
